// File: rtl/pwm_update_sequencer.sv
// Shares the single PWM_UNIT configuration port between NUM_REQ requesters.
// Accepted updates are shadowed and applied only on a PWM period boundary; also sequences start and graceful stop.
module pwm_update_sequencer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       pwm_clk,
  input  logic                       pwm_reset,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_value,
  input  logic [NUM_REQ*WIDTH-1:0]   req_range,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       pwm_period,
  output logic [WIDTH-1:0]           pwm_value,
  output logic [WIDTH-1:0]           pwm_range,
  output logic                       pwm_en,
  output logic                       busy,
  output logic                       err_clamp
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0]  pwm_value_q, pwm_value_d;
  logic [WIDTH-1:0]  pwm_range_q, pwm_range_d;
  logic [WIDTH-1:0]  shadow_value_q, shadow_value_d;
  logic [WIDTH-1:0]  shadow_range_q, shadow_range_d;
  logic              pwm_en_q, pwm_en_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              grant_ok;
  logic              gnt_valid;
  logic [PTR_W-1:0]  gnt_idx;
  logic [WIDTH-1:0]  sel_value;
  logic [WIDTH-1:0]  sel_range;
  logic              over_range;
  logic [WIDTH-1:0]  clamp_value;

  // Kept outside the FSM process so the arbiter does not form a combinational loop with it.
  assign grant_ok = enable && ((state_q == S_OFF) || (state_q == S_RUN));

  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    sel_value = '0;
    sel_range = '0;
    if (grant_ok) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = (32'(ptr_q) + k) % NUM_REQ;
        if (!gnt_valid && req_valid[idx[PTR_W-1:0]]) begin
          gnt_valid = 1'b1;
          gnt_idx   = idx[PTR_W-1:0];
        end
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt_valid && (gnt_idx == PTR_W'(k))) begin
        req_ready[k] = 1'b1;
        sel_value    = req_value[k*WIDTH +: WIDTH];
        sel_range    = req_range[k*WIDTH +: WIDTH];
      end
    end
  end

  assign over_range  = sel_value > sel_range;
  assign clamp_value = over_range ? sel_range : sel_value;

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    pwm_value_d    = pwm_value_q;
    pwm_range_d    = pwm_range_q;
    pwm_en_d       = pwm_en_q;
    shadow_value_d = shadow_value_q;
    shadow_range_d = shadow_range_q;
    err_d          = gnt_valid && over_range;

    if (gnt_valid) begin
      ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    end

    case (state_q)
      S_OFF: begin
        if (gnt_valid) begin
          pwm_value_d = clamp_value;
          pwm_range_d = sel_range;
          pwm_en_d    = 1'b1;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (!enable) begin
          state_d = S_STOP;
        end else if (gnt_valid) begin
          shadow_value_d = clamp_value;
          shadow_range_d = sel_range;
          state_d        = S_PEND;
        end
      end
      S_PEND: begin
        // A stop coinciding with the boundary wins; the pending update is dropped.
        if (!enable) begin
          state_d = S_STOP;
        end else if (pwm_period) begin
          pwm_value_d = shadow_value_q;
          pwm_range_d = shadow_range_q;
          state_d     = S_RUN;
        end
      end
      S_STOP: begin
        if (enable) begin
          state_d = S_RUN;
        end else if (pwm_period) begin
          pwm_en_d = 1'b0;
          state_d  = S_OFF;
        end
      end
      default: state_d = S_OFF;
    endcase

    busy_d = (state_d == S_PEND) || (state_d == S_STOP);
  end

  always_ff @(posedge pwm_clk or negedge pwm_reset) begin
    if (!pwm_reset) begin
      state_q        <= S_OFF;
      ptr_q          <= '0;
      pwm_value_q    <= '0;
      pwm_range_q    <= '0;
      pwm_en_q       <= 1'b0;
      shadow_value_q <= '0;
      shadow_range_q <= '0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      pwm_value_q    <= pwm_value_d;
      pwm_range_q    <= pwm_range_d;
      pwm_en_q       <= pwm_en_d;
      shadow_value_q <= shadow_value_d;
      shadow_range_q <= shadow_range_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
    end
  end

  assign pwm_value = pwm_value_q;
  assign pwm_range = pwm_range_q;
  assign pwm_en    = pwm_en_q;
  assign busy      = busy_q;
  assign err_clamp = err_q;

endmodule

// File: tb/tb_pwm_update_sequencer.sv
// Directed bench for pwm_update_sequencer: start-up, boundary-aligned updates,
// round-robin order, clamping, stop/abort and asynchronous reset.
module tb_pwm_update_sequencer;

  logic        pwm_clk;
  logic        pwm_reset;
  logic        enable;
  logic [3:0]  req_valid;
  logic [31:0] req_value;
  logic [31:0] req_range;
  logic [3:0]  req_ready;
  logic        pwm_period;
  logic [7:0]  pwm_value;
  logic [7:0]  pwm_range;
  logic        pwm_en;
  logic        busy;
  logic        err_clamp;

  int unsigned vec_cnt;
  int unsigned miss_cnt;

  pwm_update_sequencer #(
    .WIDTH   (8),
    .NUM_REQ (4)
  ) dut (
    .pwm_clk    (pwm_clk),
    .pwm_reset  (pwm_reset),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_value  (req_value),
    .req_range  (req_range),
    .req_ready  (req_ready),
    .pwm_period (pwm_period),
    .pwm_value  (pwm_value),
    .pwm_range  (pwm_range),
    .pwm_en     (pwm_en),
    .busy       (busy),
    .err_clamp  (err_clamp)
  );

  initial pwm_clk = 1'b0;
  always #5 pwm_clk = ~pwm_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pwm_clk);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic set_req(input int unsigned i, input logic [7:0] v, input logic [7:0] r);
    req_value[i*8 +: 8] = v;
    req_range[i*8 +: 8] = r;
  endtask

  task automatic pulse();
    pwm_period = 1'b1;
    tick();
    pwm_period = 1'b0;
  endtask

  logic [3:0] rr_ready [6];
  logic [7:0] rr_value [6];

  initial begin
    vec_cnt    = 0;
    miss_cnt   = 0;
    pwm_reset  = 1'b0;
    enable     = 1'b0;
    req_valid  = '0;
    req_value  = '0;
    req_range  = '0;
    pwm_period = 1'b0;
    rr_ready   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    rr_value   = '{8'd16, 8'd32, 8'd48, 8'd64, 8'd16, 8'd32};

    // Reset state, no requests afterwards
    ticks(2);
    pwm_reset = 1'b1;
    ticks(2);
    chk("rst_value", pwm_value, 0);
    chk("rst_range", pwm_range, 0);
    chk("rst_en",    pwm_en,    0);
    chk("rst_busy",  busy,      0);
    chk("rst_err",   err_clamp, 0);
    req_valid = 4'b0001;
    set_req(0, 8'd64, 8'd255);
    #1;
    chk("off_noenable_ready", req_ready, 0);
    tick();
    chk("off_noenable_en", pwm_en, 0);

    // Start-up
    enable = 1'b1;
    #1;
    chk("start_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("start_value", pwm_value, 64);
    chk("start_range", pwm_range, 255);
    chk("start_en",    pwm_en,    1);
    chk("start_busy",  busy,      0);

    // Boundary-aligned update
    set_req(1, 8'd128, 8'd255);
    req_valid = 4'b0010;
    #1;
    chk("upd_ready", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1000;
    #1;
    chk("pend_ready", req_ready, 0);
    req_valid = '0;
    chk("pend_busy", busy, 1);
    ticks(20);
    chk("pend_hold_value", pwm_value, 64);
    chk("pend_hold_busy",  busy,      1);
    pulse();
    chk("upd_value", pwm_value, 128);
    chk("upd_busy",  busy,      0);

    // Grant coincident with a pulse goes to the shadow only
    set_req(2, 8'd30, 8'd255);
    req_valid  = 4'b0100;
    pwm_period = 1'b1;
    #1;
    chk("coinc_ready", req_ready, 4'b0100);
    tick();
    req_valid  = '0;
    pwm_period = 1'b0;
    chk("coinc_value", pwm_value, 128);
    chk("coinc_busy",  busy,      1);
    ticks(3);
    pulse();
    chk("coinc_applied", pwm_value, 30);

    // Clamp: pointer is at 3, so search wraps to requester 2
    set_req(2, 8'd200, 8'd100);
    req_valid = 4'b0100;
    #1;
    chk("clamp_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    chk("clamp_err_on", err_clamp, 1);
    tick();
    chk("clamp_err_off", err_clamp, 0);
    chk("clamp_pend_value", pwm_value, 30);
    pulse();
    chk("clamp_value", pwm_value, 100);
    chk("clamp_range", pwm_range, 100);

    // Stop from PEND discards the shadow
    set_req(3, 8'd50, 8'd255);
    req_valid = 4'b1000;
    #1;
    chk("stop_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    enable    = 1'b0;
    tick();
    chk("stop_busy", busy, 1);
    chk("stop_en",   pwm_en, 1);
    ticks(3);
    chk("stop_hold_en", pwm_en, 1);
    pulse();
    chk("stop_off_en",   pwm_en,    0);
    chk("stop_off_busy", busy,      0);
    chk("stop_value",    pwm_value, 100);
    chk("stop_range",    pwm_range, 100);
    pulse();
    chk("off_ignores_period", pwm_en, 0);

    // Restart, then abort a stop by re-enabling
    enable = 1'b1;
    set_req(0, 8'd10, 8'd20);
    req_valid = 4'b0001;
    #1;
    chk("restart_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("restart_value", pwm_value, 10);
    chk("restart_en",    pwm_en,    1);
    set_req(1, 8'd40, 8'd255);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    enable    = 1'b0;
    tick();
    chk("abort_stop_busy", busy, 1);
    enable = 1'b1;
    tick();
    chk("abort_busy",  busy,      0);
    chk("abort_en",    pwm_en,    1);
    chk("abort_value", pwm_value, 10);
    pulse();
    chk("abort_discarded", pwm_value, 10);
    chk("abort_en_after",  pwm_en,    1);

    // Asynchronous reset mid-cycle
    #3;
    pwm_reset = 1'b0;
    #1;
    chk("arst_en",    pwm_en,    0);
    chk("arst_value", pwm_value, 0);
    chk("arst_range", pwm_range, 0);
    #2;
    pwm_reset = 1'b1;
    tick();

    // Round-robin with all requesters held valid
    for (int unsigned i = 0; i < 4; i++) set_req(i, 8'(16 * (i + 1)), 8'd255);
    req_valid = 4'b1111;
    #1;
    chk("rr_ready_0", req_ready, rr_ready[0]);
    tick();
    chk("rr_value_0", pwm_value, rr_value[0]);
    for (int unsigned k = 1; k < 6; k++) begin
      chk($sformatf("rr_ready_%0d", k), req_ready, rr_ready[k]);
      tick();
      chk($sformatf("rr_busy_%0d", k), busy, 1);
      chk($sformatf("rr_noready_%0d", k), req_ready, 0);
      ticks(8);
      pulse();
      chk($sformatf("rr_value_%0d", k), pwm_value, rr_value[k]);
    end

    // Zero range clamps any nonzero value to 0
    req_valid = 4'b0100;
    set_req(2, 8'd5, 8'd0);
    #1;
    chk("zr_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    chk("zr_err", err_clamp, 1);
    pulse();
    chk("zr_value", pwm_value, 0);
    chk("zr_range", pwm_range, 0);
    chk("zr_err_off", err_clamp, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
